fft_sample_framer: RTL

Double-buffered input framer for the 16-point FFT datapath. Accepts a stream of signed 16-bit real samples, assembles them into 16-sample frames, and presents each frame to the FFT core as a parallel array of packed complex words {real, imag = 0}. It issues a single-cycle `fft_start` per frame and tracks the FFT's `done`. While the FFT consumes one bank, the next frame fills the other; overruns are counted, never silently corrupt data.

---
 rtl/fft_sample_framer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fft_sample_framer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fft_sample_framer: double-buffered 16-sample framer feeding the FFT.    |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module fft_sample_framer #(
  parameter int N        = 16,
  parameter int SAMPLE_W = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [SAMPLE_W-1:0]                sample_in,
  input  logic                               sample_valid,
  input  logic                               fft_done,
  output logic [N-1:0][2*SAMPLE_W-1:0]       frame,
  output logic                               fft_start,
  output logic                               busy,
  output logic                               overrun,
  output logic [7:0]                         drop_count
);

  localparam int              CNT_W  = $clog2(N);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

  logic [SAMPLE_W-1:0] bank_q [2][N];
  logic [SAMPLE_W-1:0] bank_d [2][N];
  logic [CNT_W-1:0]    fill_cnt_q, fill_cnt_d;
  logic                fill_bank_q, fill_bank_d;
  logic                out_bank_q, out_bank_d;
  logic                busy_q, busy_d;
  logic                pending_q, pending_d;
  logic                done_q, done_d;
  logic                fft_start_q, fft_start_d;
  logic                overrun_q, overrun_d;
  logic [7:0]          drop_count_q, drop_count_d;

  logic w_done_edge, w_accept, w_drop, w_complete, w_launch_now, w_launch_pend, w_launch;

  always_comb begin
    // A done edge only matters while the FFT actually holds a frame.
    w_done_edge   = fft_done & ~done_q & busy_q;
    w_accept      = sample_valid & ~pending_q;
    w_drop        = sample_valid & pending_q;
    w_complete    = w_accept && (fill_cnt_q == C_LAST);
    w_launch_now  = w_complete & (~busy_q | w_done_edge);
    w_launch_pend = w_done_edge & pending_q;
    w_launch      = w_launch_now | w_launch_pend;

    bank_d       = bank_q;
    fill_cnt_d   = fill_cnt_q;
    fill_bank_d  = fill_bank_q;
    out_bank_d   = out_bank_q;
    busy_d       = busy_q;
    pending_d    = pending_q;
    done_d       = fft_done;
    fft_start_d  = w_launch;
    overrun_d    = w_drop;
    drop_count_d = drop_count_q;

    if (w_accept) begin
      bank_d[fill_bank_q][fill_cnt_q] = sample_in;
      fill_cnt_d = w_complete ? '0 : fill_cnt_q + 1'b1;
    end

    if (w_launch) begin
      out_bank_d  = fill_bank_q;
      fill_bank_d = ~fill_bank_q;
      busy_d      = 1'b1;
    end else if (w_done_edge) begin
      busy_d = 1'b0;
    end

    if (w_launch_pend) begin
      pending_d = 1'b0;
    end else if (w_complete && !w_launch_now) begin
      pending_d = 1'b1;
    end

    if (w_drop && drop_count_q != 8'hFF) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  // out_bank starts on the idle bank so the first frame's fill stays hidden
  // until it launches; both banks are zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          bank_q[b][i] <= '0;
        end
      end
      fill_cnt_q   <= '0;
      fill_bank_q  <= 1'b0;
      out_bank_q   <= 1'b1;
      busy_q       <= 1'b0;
      pending_q    <= 1'b0;
      done_q       <= 1'b0;
      fft_start_q  <= 1'b0;
      overrun_q    <= 1'b0;
      drop_count_q <= '0;
    end else begin
      bank_q       <= bank_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_bank_q  <= fill_bank_d;
      out_bank_q   <= out_bank_d;
      busy_q       <= busy_d;
      pending_q    <= pending_d;
      done_q       <= done_d;
      fft_start_q  <= fft_start_d;
      overrun_q    <= overrun_d;
      drop_count_q <= drop_count_d;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_frame
    assign frame[gi] = {bank_q[out_bank_q][gi], {SAMPLE_W{1'b0}}};
  end

  assign fft_start  = fft_start_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign drop_count = drop_count_q;

endmodule
`default_nettype wire
